// File: rtl/rsa_io_sched.sv
// Word-serial operand loader, core launcher, result capture buffer and host drain for the RSA core.
// Latency: 16 accepted words, 1 START cycle, WAIT, 16 SER cycles; out_valid/out_data are registered and held while out_ready is low.
module rsa_io_sched #(
  parameter int RSA_LEN = 512,
  parameter int BUS_W   = 32,
  parameter int TMO_W   = 24
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [BUS_W-1:0]   in_data,
  output logic               in_ready,
  output logic               out_valid,
  output logic [BUS_W-1:0]   out_data,
  input  logic               out_ready,
  output logic               busy,
  output logic               err,
  output logic [RSA_LEN-1:0] core_din,
  output logic               core_start,
  input  logic               core_done,
  output logic               ser_load,
  input  logic [BUS_W-1:0]   ser_data
);
  localparam int WORDS = RSA_LEN / BUS_W;
  localparam int IDX_W = $clog2(WORDS);
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_SER, S_DRAIN} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 err_q, err_d;
  logic [RSA_LEN-1:0]   din_q, din_d;
  logic                 out_vld_q;
  logic [BUS_W-1:0]     out_dat_q;
  logic [BUS_W-1:0]     res_buf_q [WORDS];
  logic                 rdy_c;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    err_d      = err_q;
    din_d      = din_q;
    rdy_c      = 1'b0;
    core_start = 1'b0;
    ser_load   = 1'b0;
    case (state_q)
      S_IDLE: begin
        rdy_c = 1'b1;
        if (in_valid) begin
          din_d[BUS_W-1:0] = in_data;
          cnt_d            = CNT_W'(1);
          err_d            = 1'b0;
          state_d          = S_LOAD;
        end
      end
      S_LOAD: begin
        rdy_c = 1'b1;
        if (in_valid) begin
          din_d[int'(cnt_q[IDX_W-1:0]) * BUS_W +: BUS_W] = in_data;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST) state_d = S_START;
        end
      end
      S_START: begin
        core_start = 1'b1;
        tmo_d      = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        tmo_d = tmo_q + TMO_W'(1);
        // A completion arriving on the final timeout cycle still counts as success.
        if (core_done) begin
          ser_load = 1'b1;
          cnt_d    = '0;
          state_d  = S_SER;
        end else if (tmo_d == '1) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_SER: begin
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        if (out_ready) begin
          if (cnt_q == LAST) begin
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      tmo_q     <= '0;
      err_q     <= 1'b0;
      din_q     <= '0;
      out_vld_q <= 1'b0;
      out_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      din_q     <= din_d;
      // Output word is preloaded from the next-state index so the first DRAIN cycle is already valid.
      out_vld_q <= (state_d == S_DRAIN);
      out_dat_q <= (state_d == S_DRAIN) ? res_buf_q[cnt_d[IDX_W-1:0]] : '0;
    end
  end

  // The serializer cannot be stalled, so capture runs every SER cycle unconditionally.
  always_ff @(posedge clk) begin
    if (state_q == S_SER) res_buf_q[cnt_q[IDX_W-1:0]] <= ser_data;
  end

  assign in_ready  = rst_n & rdy_c;
  assign out_valid = out_vld_q;
  assign out_data  = out_dat_q;
  assign busy      = (state_q != S_IDLE);
  assign err       = err_q;
  assign core_din  = din_q;
endmodule

// File: tb/tb_rsa_io_sched.sv
// Directed bench for rsa_io_sched with core/serializer models and an output scoreboard.
module tb_rsa_io_sched;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic [31:0]  in_data = '0;
  logic         in_ready;
  logic         out_valid;
  logic [31:0]  out_data;
  logic         out_ready = 1'b1;
  logic         busy;
  logic         err;
  logic [511:0] core_din;
  logic         core_start;
  logic         core_done = 1'b0;
  logic         ser_load;
  logic [31:0]  ser_data = '0;

  always #5 clk = ~clk;

  rsa_io_sched #(.RSA_LEN(512), .BUS_W(32), .TMO_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .err(err), .core_din(core_din),
    .core_start(core_start), .core_done(core_done),
    .ser_load(ser_load), .ser_data(ser_data)
  );

  int           n_chk = 0;
  int           n_pass = 0;
  logic [31:0]  sb[$];
  logic [31:0]  op_w[16];
  logic [511:0] exp_din;
  logic [31:0]  ser_src[16];
  logic [31:0]  exp_w;
  logic [31:0]  held = '0;
  logic [3:0]   pat = 4'b1001;
  int           cyc = 0, start_cyc = -1000, ser_t = -1000;
  int           n_start = 0, n_ser = 0, s_start, s_ser, rdy_idx = 0, core_dly = 5;
  bit           done_en = 1'b1, ser_mode = 1'b0, rdy_mode = 1'b0, stall_q = 1'b0;
  logic         err0 = 1'b0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    n_chk++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Core and serializer models plus host out_ready, driven just after each rising edge.
  always @(posedge clk) begin
    cyc++;
    #1;
    core_done = done_en && (cyc == start_cyc + core_dly);
    if (cyc > ser_t && cyc <= ser_t + 16) ser_data = ser_src[cyc - ser_t - 1];
    else ser_data = 32'hDEAD0000 | 32'(cyc & 32'hFFFF);
    out_ready = rdy_mode ? pat[rdy_idx % 4] : 1'b1;
    rdy_idx++;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (core_start) begin start_cyc = cyc; n_start++; end
      if (ser_load) begin
        ser_t = cyc;
        n_ser++;
        for (int k = 0; k < 16; k++)
          ser_src[k] = ser_mode ? (32'hA0000000 + 32'(k)) : core_din[k*32 +: 32];
      end
      if (stall_q) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, held);
      end
      if (out_valid && out_ready) begin
        if (sb.size() > 0) exp_w = sb.pop_front();
        else exp_w = 32'hFFFFFFFF;
        check("out_word", out_data, exp_w);
      end
      stall_q = out_valid && !out_ready;
      held    = out_data;
    end
  end

  task automatic load_op(input logic [31:0] base, input logic [31:0] step);
    for (int k = 0; k < 16; k++) begin
      op_w[k] = base + step * 32'(k);
      exp_din[k*32 +: 32] = op_w[k];
    end
  endtask

  task automatic push_exp(input bit markers);
    for (int k = 0; k < 16; k++) sb.push_back(markers ? (32'hA0000000 + 32'(k)) : op_w[k]);
  endtask

  task automatic send_op(input int first, input bit gaps);
    for (int k = first; k < 16; k++) begin
      int t;
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = op_w[k];
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 64) begin @(negedge clk); t++; end
      check("accept_wait", t < 64, 1);
      @(posedge clk);
      #1;
      if (k == 0) err0 = err;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || sb.size() != 0) && t < 500) begin @(negedge clk); t++; end
    check(tag, t < 500, 1);
  endtask

  initial begin
    int t;
    #3;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_core_din", core_din, 0);
    check("rst_core_start", core_start, 0);
    check("rst_ser_load", ser_load, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Nominal loopback; next operand's first word is offered early and must wait for IDLE.
    load_op(32'h0, 32'h1);
    push_exp(1'b0);
    s_start = n_start; s_ser = n_ser;
    send_op(0, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'hA5A50000;
    wait_idle("nom_idle");
    check("b2b_in_ready", in_ready, 1);
    check("nom_core_din", core_din, exp_din);
    check("nom_start_cnt", n_start - s_start, 1);
    check("nom_ser_cnt", n_ser - s_ser, 1);
    check("nom_ser_lat", ser_t - start_cyc, 5);

    // Alignment markers, first word accepted in the first IDLE cycle.
    load_op(32'hA5A50000, 32'h1);
    @(posedge clk);
    #1;
    ser_mode = 1'b1;
    push_exp(1'b1);
    send_op(1, 1'b0);
    wait_idle("align_idle");
    check("align_core_din", core_din, exp_din);
    ser_mode = 1'b0;

    // Backpressure with random input gaps.
    for (int k = 0; k < 16; k++) begin
      op_w[k] = $urandom & 32'h7FFFFFFF;
      exp_din[k*32 +: 32] = op_w[k];
    end
    push_exp(1'b0);
    rdy_mode = 1'b1;
    @(posedge clk);
    #1;
    send_op(0, 1'b1);
    wait_idle("bp_idle");
    check("bp_core_din", core_din, exp_din);
    rdy_mode = 1'b0;

    // Timeout: core never completes.
    done_en = 1'b0;
    s_ser = n_ser;
    load_op(32'h50000000, 32'h1);
    @(posedge clk);
    #1;
    send_op(0, 1'b0);
    t = 0;
    @(negedge clk);
    while (!core_start && t < 10) begin @(negedge clk); t++; end
    check("tmo_start_seen", t < 10, 1);
    repeat (14) @(negedge clk);
    check("tmo_busy", busy, 1);
    @(negedge clk);
    check("tmo_err_early", err, 0);
    @(negedge clk);
    check("tmo_err", err, 1);
    check("tmo_idle", busy, 0);
    check("tmo_no_ser_load", n_ser - s_ser, 0);

    // Race: core_done lands on the last timeout cycle.
    done_en = 1'b1;
    core_dly = 15;
    s_ser = n_ser;
    load_op(32'h60000000, 32'h3);
    push_exp(1'b0);
    @(posedge clk);
    #1;
    send_op(0, 1'b0);
    check("err_cleared", err0, 0);
    wait_idle("race_idle");
    check("race_err", err, 0);
    check("race_ser_lat", ser_t - start_cyc, 15);
    check("race_ser_cnt", n_ser - s_ser, 1);
    core_dly = 5;

    // Reset during DRAIN word 7, then a fresh operand.
    load_op(32'h70000000, 32'h1);
    push_exp(1'b0);
    @(posedge clk);
    #1;
    send_op(0, 1'b0);
    t = 0;
    @(negedge clk);
    while (!(out_valid && out_data == op_w[7]) && t < 200) begin @(negedge clk); t++; end
    check("drain_w7_seen", t < 200, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_core_din", core_din, 0);
    check("mid_rst_err", err, 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    load_op(32'h80000000, 32'h5);
    push_exp(1'b0);
    @(posedge clk);
    #1;
    send_op(0, 1'b0);
    wait_idle("post_rst_idle");
    check("post_rst_core_din", core_din, exp_din);
    check("sb_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rsa_io_sched.md
# rsa_io_sched

Word-serial I/O sequencer for the RSA core. It collects a RSA_LEN-bit operand from a BUS_W-bit host stream and starts the core. After the core reports completion, it triggers the existing parallel-to-serial result shifter and captures its unthrottled 16-word burst into a local buffer. It then drains that buffer to the host under valid/ready flow control, with a completion timeout.

## Interface
- RSA_LEN, 512, operand/result width
- BUS_W, 32, host word width; WORDS = RSA_LEN/BUS_W (16)
- TMO_W, 24, width of the core-completion timeout counter; timeout = 2^TMO_W-1 cycles
- clk  in  1  clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  host operand word valid
- in_data  in  BUS_W  operand word, least-significant word first
- in_ready  out  1  operand word accepted when in_valid && in_ready
- out_valid  out  1  result word valid
- out_data  out  BUS_W  result word, least-significant word first
- out_ready  in  1  host accepts result word
- busy  out  1  high in every state except IDLE
- err  out  1  sticky timeout flag; cleared by the next accepted operand word
- core_din  out  RSA_LEN  assembled operand, stable from START until the next LOAD
- core_start  out  1  one-cycle start pulse to the core
- core_done  in  1  core completion pulse (level tolerated)
- ser_load  out  1  one-cycle load pulse to the serializer's rdy input
- ser_data  in  BUS_W  serializer output word

## Operation
- States: IDLE, LOAD, START, WAIT, SER, DRAIN.
- IDLE: in_ready=1. The first accepted word is written to core_din word 0, sets cnt=1, clears err, and moves to LOAD.
- LOAD: in_ready=1. Each accepted word is written to core_din[cnt*BUS_W +: BUS_W] and cnt increments. Acceptance of word WORDS-1 moves to START. in_valid low inserts wait cycles only.
- START: core_start=1 for exactly one cycle, tmo cleared, then WAIT.
- WAIT: tmo increments each cycle.
  - core_done=1: ser_load=1 for this cycle only, cnt=0, go to SER.
  - tmo reaching all-ones without core_done: err=1, go to IDLE. No ser_load is issued.
  - core_done and the tmo limit in the same cycle: core_done wins.
- SER: buffer[cnt] <= ser_data every cycle with no stall. This is mandatory because the serializer cannot be throttled. After 16 captures, cnt=0 and go to DRAIN.
- DRAIN: out_valid=1, out_data=buffer[cnt]. On out_valid && out_ready, cnt increments. The handshake on word WORDS-1 returns to IDLE.
- in_ready=0 in START, WAIT, SER and DRAIN. Host words offered in those states are not consumed.
- core_done outside WAIT is ignored.
- cnt is $clog2(WORDS)+1 bits wide. Compare against WORDS-1 explicitly; never rely on wrap-around.

## Timing
- Reset (async assert, sync deassert assumed upstream): state=IDLE, cnt=0, tmo=0. Outputs: in_ready=0 while rst_n low, then 1 in the first IDLE cycle. out_valid=0, out_data=0, core_start=0, ser_load=0, busy=0, err=0, core_din=0. The buffer is not reset.
- Reset mid-operation returns immediately to IDLE with the values above. Partial operands and results are discarded.
- Operand: minimum 16 cycles of LOAD/IDLE acceptance, then 1 START cycle.
- Serializer alignment: if ser_load is high in cycle T, ser_data holds result word k during cycle T+1+k for k=0..15. The SER state spans exactly cycles T+1..T+16. The first DRAIN cycle is T+17.
- out_data/out_valid are registered and hold stable while out_valid && !out_ready.
- Back-to-back: the final DRAIN handshake leads to IDLE, and the next operand word can be accepted one cycle later.

## Test plan
- Nominal: send words 0x00000000..0x0000000F with in_valid held. Loopback model returns core_done 5 cycles after core_start, and the serializer model returns core_din. Expect core_din word k = k, one core_start pulse, one ser_load pulse, and 16 outputs 0x0..0xF in order.
- Alignment: ser_load at cycle T, with ser_data driven as T-relative markers 0xA0000000+k at T+1+k. Buffer must hold exactly those 16 values; any off-by-one fails.
- Backpressure: out_ready toggles 1,0,0,1 pattern and in_valid has random gaps. No word is lost or duplicated, out_data is stable while stalled, and capture is unaffected.
- Timeout: TMO_W=4, core_done never asserted. err=1 after 15 WAIT cycles, return to IDLE, no ser_load. The next operand's first word clears err.
- Race: core_done coincides with tmo=all-ones. Expect ser_load=1, err stays 0, and normal drain follows.
- Reset: assert rst_n=0 during DRAIN word 7. All outputs reach reset values asynchronously. A fresh operand afterwards completes normally with no stale words.
